// File: rtl/fpga_link_pkg.sv
// Shared types and default timing for the inter-FPGA strobe link master.
package fpga_link_pkg;

  localparam int LINK_DATA_W     = 8;
  localparam int LINK_SETUP_CYC  = 2;
  localparam int LINK_STROBE_CYC = 4;
  localparam int LINK_HOLD_CYC   = 2;
  localparam int LINK_TURN_CYC   = 2;
  localparam int LINK_CNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_SETUP  = 3'd1,
    ST_WR_STROBE = 3'd2,
    ST_WR_HOLD   = 3'd3,
    ST_RD_STROBE = 3'd4,
    ST_RD_TURN   = 3'd5
  } link_state_t;

  // True when every phase length meets its minimum and fits the counter.
  // STROBE needs at least 3 cycles so the 2-flop read synchronizer settles.
  function automatic bit link_cfg_ok(input int setup, input int strobe,
                                     input int hold, input int turn,
                                     input int cnt_w);
    int lim;
    lim = 32'sd1 << cnt_w;
    return (setup >= 32'sd1) && (strobe >= 32'sd3) && (hold >= 32'sd1) &&
           (turn >= 32'sd1) && (setup < lim) && (strobe < lim) &&
           (hold < lim) && (turn < lim);
  endfunction

endpackage

// File: rtl/fpga_link_if.sv
// Request/response handshake plus split-tristate link signals of the link master.
interface fpga_link_if;
  import fpga_link_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [LINK_DATA_W-1:0] req_wdata;
  logic                   done;
  logic [LINK_DATA_W-1:0] rsp_rdata;
  logic                   link_w;
  logic                   link_r;
  logic [LINK_DATA_W-1:0] link_data_o;
  logic                   link_data_oe;
  logic [LINK_DATA_W-1:0] link_data_i;

  // View of the link master itself.
  modport master (
    input  req_valid, req_write, req_wdata, link_data_i,
    output req_ready, done, rsp_rdata, link_w, link_r, link_data_o, link_data_oe
  );

  // View of the requester / pad side that talks to the master.
  modport slave (
    output req_valid, req_write, req_wdata, link_data_i,
    input  req_ready, done, rsp_rdata, link_w, link_r, link_data_o, link_data_oe
  );

endinterface

// File: rtl/fpga_link_sync.sv
// Two-flop synchronizer bringing the asynchronous DATA pad into the clk domain.
module fpga_link_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  // Shift the pad value one stage per clock.
  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  // Synchronizer flops, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= {W{1'b0}};
      sync_q <= {W{1'b0}};
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fpga_link_master.sv
// Upper-FPGA master for the W/R/DATA strobe link: turns one register request
// into setup/strobe/hold (write) or strobe/turnaround (read) timing.
module fpga_link_master
  import fpga_link_pkg::*;
#(
  parameter int SETUP_CYC  = LINK_SETUP_CYC,
  parameter int STROBE_CYC = LINK_STROBE_CYC,
  parameter int HOLD_CYC   = LINK_HOLD_CYC,
  parameter int TURN_CYC   = LINK_TURN_CYC,
  parameter int CNT_W      = LINK_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  fpga_link_if.master bus
);

  if (!link_cfg_ok(SETUP_CYC, STROBE_CYC, HOLD_CYC, TURN_CYC, CNT_W)) begin : g_cfg_err
    $error("fpga_link_master: illegal timing parameters");
  end

  // The counter is loaded with N-1 on state entry and the phase ends at zero.
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 32'sd1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 32'sd1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 32'sd1);
  localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYC - 32'sd1);

  link_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   link_w_q, link_w_d;
  logic                   link_r_q, link_r_d;
  logic                   data_oe_q, data_oe_d;
  logic [LINK_DATA_W-1:0] data_o_q, data_o_d;
  logic                   done_q, done_d;
  logic [LINK_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                   req_ready_q, req_ready_d;

  logic                   accept_s;
  logic                   cnt_zero_s;
  logic [LINK_DATA_W-1:0] sync_data_s;

  fpga_link_sync #(.W(LINK_DATA_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.link_data_i),
    .q_o (sync_data_s)
  );

  assign accept_s   = bus.req_valid & req_ready_q;
  assign cnt_zero_s = (cnt_q == CNT_ZERO);

  // State and phase-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: advance a phase when its counter expires, reload on entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (bus.req_write) begin
            state_d = ST_WR_SETUP;
            cnt_d   = SETUP_LOAD;
          end else begin
            state_d = ST_RD_STROBE;
            cnt_d   = STROBE_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      ST_WR_SETUP: begin
        if (cnt_zero_s) begin
          state_d = ST_WR_STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_WR_STROBE: begin
        if (cnt_zero_s) begin
          state_d = ST_WR_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_WR_HOLD: begin
        if (cnt_zero_s) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_RD_STROBE: begin
        if (cnt_zero_s) begin
          state_d = ST_RD_TURN;
          cnt_d   = TURN_LOAD;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_RD_TURN: begin
        if (cnt_zero_s) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so every pin comes from a flop
  // and lines up with the state it belongs to.
  always_comb begin
    link_w_d    = (state_d == ST_WR_STROBE);
    link_r_d    = (state_d == ST_RD_STROBE);
    data_oe_d   = (state_d == ST_WR_SETUP) || (state_d == ST_WR_STROBE) ||
                  (state_d == ST_WR_HOLD);
    req_ready_d = (state_d == ST_IDLE);
    done_d      = cnt_zero_s && ((state_q == ST_WR_HOLD) || (state_q == ST_RD_TURN));
    if (accept_s && bus.req_write) begin
      data_o_d = bus.req_wdata;
    end else if (data_oe_d) begin
      data_o_d = data_o_q;
    end else begin
      data_o_d = {LINK_DATA_W{1'b0}};
    end
    // Sample the synchronized pad on the edge closing the last strobe cycle.
    if ((state_q == ST_RD_STROBE) && cnt_zero_s) begin
      rsp_rdata_d = sync_data_s;
    end else begin
      rsp_rdata_d = rsp_rdata_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_w_q    <= 1'b0;
      link_r_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      data_o_q    <= {LINK_DATA_W{1'b0}};
      done_q      <= 1'b0;
      rsp_rdata_q <= {LINK_DATA_W{1'b0}};
      req_ready_q <= 1'b1;
    end else begin
      link_w_q    <= link_w_d;
      link_r_q    <= link_r_d;
      data_oe_q   <= data_oe_d;
      data_o_q    <= data_o_d;
      done_q      <= done_d;
      rsp_rdata_q <= rsp_rdata_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign bus.link_w       = link_w_q;
  assign bus.link_r       = link_r_q;
  assign bus.link_data_oe = data_oe_q;
  assign bus.link_data_o  = data_o_q;
  assign bus.done         = done_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.req_ready    = req_ready_q;

endmodule

// File: tb/tb_fpga_link_master.sv
// Directed bench for fpga_link_master: default-timing instance plus a
// STROBE=3/TURN=1 instance, with continuous link-invariant checks.
module tb_fpga_link_master;
  import fpga_link_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   inv_en;

  fpga_link_if bus_a ();
  fpga_link_if bus_b ();

  fpga_link_master dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  fpga_link_master #(
    .SETUP_CYC  (2),
    .STROBE_CYC (3),
    .HOLD_CYC   (2),
    .TURN_CYC   (1),
    .CNT_W      (4)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare the control pins of instance A against one expected snapshot.
  task automatic check_a(input string t, input int c, input logic w, input logic r,
                         input logic oe, input logic dn, input logic rdy);
    check($sformatf("%s_w_c%0d", t, c),     {31'd0, bus_a.link_w},       {31'd0, w});
    check($sformatf("%s_r_c%0d", t, c),     {31'd0, bus_a.link_r},       {31'd0, r});
    check($sformatf("%s_oe_c%0d", t, c),    {31'd0, bus_a.link_data_oe}, {31'd0, oe});
    check($sformatf("%s_done_c%0d", t, c),  {31'd0, bus_a.done},         {31'd0, dn});
    check($sformatf("%s_ready_c%0d", t, c), {31'd0, bus_a.req_ready},    {31'd0, rdy});
  endtask

  // Link invariants on both instances, sampled mid-cycle.
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      assert (((bus_a.link_w & bus_a.link_r) === 1'b0) &&
              ((bus_a.link_w & ~bus_a.link_data_oe) === 1'b0) &&
              ((bus_a.link_r & bus_a.link_data_oe) === 1'b0)) else begin
        errors++;
        $error("FAIL inv_a observed w=%b r=%b oe=%b", bus_a.link_w, bus_a.link_r, bus_a.link_data_oe);
      end
      checks++;
      assert (((bus_b.link_w & bus_b.link_r) === 1'b0) &&
              ((bus_b.link_w & ~bus_b.link_data_oe) === 1'b0) &&
              ((bus_b.link_r & bus_b.link_data_oe) === 1'b0)) else begin
        errors++;
        $error("FAIL inv_b observed w=%b r=%b oe=%b", bus_b.link_w, bus_b.link_r, bus_b.link_data_oe);
      end
    end
  end

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    checks = 0;
    errors = 0;
    inv_en = 1'b0;
    bus_a.req_valid   = 1'b0;
    bus_a.req_write   = 1'b0;
    bus_a.req_wdata   = 8'h00;
    bus_a.link_data_i = 8'h00;
    bus_b.req_valid   = 1'b0;
    bus_b.req_write   = 1'b0;
    bus_b.req_wdata   = 8'h00;
    bus_b.link_data_i = 8'h00;

    // Reset values.
    tick();
    tick();
    inv_en = 1'b1;
    check_a("rst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_data_o", {24'd0, bus_a.link_data_o}, 32'h00);
    check("rst_rdata",  {24'd0, bus_a.rsp_rdata},   32'h00);
    check("rst_b_ready", {31'd0, bus_b.req_ready},  32'd1);
    rst = 1'b0;
    tick();

    // Write 0xA5: setup 1..2, W 3..6, hold 7..8, done 9.
    bus_a.req_valid = 1'b1;
    bus_a.req_write = 1'b1;
    bus_a.req_wdata = 8'hA5;
    check("wr_ready_c0", {31'd0, bus_a.req_ready}, 32'd1);
    tick();
    bus_a.req_valid = 1'b0;
    bus_a.req_wdata = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      check_a("wr", c, (c >= 3) && (c <= 6), 1'b0, c <= 8, c == 9, c >= 9);
      check($sformatf("wr_data_o_c%0d", c), {24'd0, bus_a.link_data_o},
            (c <= 8) ? 32'hA5 : 32'h00);
      tick();
    end

    // Read: pad shows 0x3C while R is high; R 1..4, done 7.
    bus_a.req_valid = 1'b1;
    bus_a.req_write = 1'b0;
    tick();
    bus_a.req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      bus_a.link_data_i = (c <= 4) ? 8'h3C : 8'h00;
      check_a("rd", c, 1'b0, (c >= 1) && (c <= 4), 1'b0, c == 7, c >= 7);
      if (c == 7) begin
        check("rd_rdata_c7", {24'd0, bus_a.rsp_rdata}, 32'h3C);
      end
      tick();
    end
    check("rd_rdata_hold", {24'd0, bus_a.rsp_rdata}, 32'h3C);

    // Back-to-back: write 0x11, then read returning 0xF0 with valid held high.
    bus_a.req_valid = 1'b1;
    bus_a.req_write = 1'b1;
    bus_a.req_wdata = 8'h11;
    tick();
    bus_a.req_write = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c == 10) begin
        bus_a.req_valid = 1'b0;
      end
      bus_a.link_data_i = ((c >= 10) && (c <= 13)) ? 8'hF0 : 8'h00;
      check_a("b2b", c, (c >= 3) && (c <= 6), (c >= 10) && (c <= 13), c <= 8,
              (c == 9) || (c == 16), (c == 9) || (c >= 16));
      if (c == 2) begin
        check("b2b_data_o_c2", {24'd0, bus_a.link_data_o}, 32'h11);
      end
      if (c == 16) begin
        check("b2b_rdata_c16", {24'd0, bus_a.rsp_rdata}, 32'hF0);
      end
      tick();
    end

    // Reset in cycle 4 of a write: link idle from cycle 5, no done.
    bus_a.req_valid = 1'b1;
    bus_a.req_write = 1'b1;
    bus_a.req_wdata = 8'h5A;
    tick();
    bus_a.req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check_a("rstw", c, c >= 3, 1'b0, 1'b1, 1'b0, 1'b0);
      if (c == 4) begin
        rst = 1'b1;
      end
      tick();
    end
    rst = 1'b0;
    check("rstw_data_o_c5", {24'd0, bus_a.link_data_o}, 32'h00);
    check("rstw_rdata_c5",  {24'd0, bus_a.rsp_rdata},   32'h00);
    for (int c = 5; c <= 12; c++) begin
      check_a("rstw", c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end

    // Read after the aborted write completes normally.
    bus_a.req_valid = 1'b1;
    bus_a.req_write = 1'b0;
    tick();
    bus_a.req_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      bus_a.link_data_i = (c <= 4) ? 8'h96 : 8'h00;
      check_a("rdpost", c, 1'b0, c <= 4, 1'b0, c == 7, c >= 7);
      if (c == 7) begin
        check("rdpost_rdata_c7", {24'd0, bus_a.rsp_rdata}, 32'h96);
      end
      tick();
    end

    // STROBE=3, TURN=1: pad becomes 0x7E in cycle 1; R 1..3, done 5.
    bus_b.req_valid = 1'b1;
    bus_b.req_write = 1'b0;
    tick();
    bus_b.req_valid   = 1'b0;
    bus_b.link_data_i = 8'h7E;
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("b_r_c%0d", c),     {31'd0, bus_b.link_r},       {31'd0, c <= 3});
      check($sformatf("b_oe_c%0d", c),    {31'd0, bus_b.link_data_oe}, 32'd0);
      check($sformatf("b_done_c%0d", c),  {31'd0, bus_b.done},         {31'd0, c == 5});
      check($sformatf("b_ready_c%0d", c), {31'd0, bus_b.req_ready},    {31'd0, c >= 5});
      if (c == 5) begin
        check("b_rdata_c5", {24'd0, bus_b.rsp_rdata}, 32'h7E);
      end
      tick();
    end

    inv_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpga_link_master.md
Name: fpga_link_master

Overview:
- Upper-FPGA bus master for the inter-FPGA strobe link that drives the lower-FPGA LED/switch register (W, R, 8-bit DATA).
- Converts a single-beat valid/ready register request (write byte or read byte) into correctly timed W/R strobes with setup, hold and bus-turnaround.
- Returns read data and a completion pulse.
- Sits between the upper-FPGA control logic and the top-level IOBUF for DATA. The IOBUF is instantiated at top level; this block uses split o/oe/i signals.

Parameters:
- SETUP_CYC, 2, cycles DATA is driven before W rises (>=1)
- STROBE_CYC, 4, cycles W or R is held high (>=3, needed for the 2-flop read sync)
- HOLD_CYC, 2, cycles DATA is held after W falls (>=1)
- TURN_CYC, 2, idle cycles after R falls before the next request can be accepted (>=1)
- CNT_W, 4, width of the timing counter; every *_CYC must be < 2**CNT_W

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1=write, 0=read
- req_wdata  in  8  write byte
- done  out  1  one-cycle completion pulse, for both reads and writes
- rsp_rdata  out  8  read byte, valid while done=1 after a read; holds its value otherwise
- link_w  out  1  W strobe to lower FPGA
- link_r  out  1  R strobe to lower FPGA
- link_data_o  out  8  DATA drive value
- link_data_oe  out  1  DATA output enable
- link_data_i  in  8  DATA pad input (asynchronous to clk)

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (clk, rst).
- All outputs are registered.
- Reset values: link_w=0, link_r=0, link_data_oe=0, link_data_o=0, done=0, rsp_rdata=0, req_ready=1, state=IDLE.
- Link idle levels: W=0, R=0, bus released.
- Invariant: link_w and link_r are never both 1. link_w=1 only while link_data_oe=1. link_r=1 only while link_data_oe=0.
- Handshake:
  - req_ready=1 only in IDLE.
  - A request is accepted on the edge where req_valid & req_ready; req_write and req_wdata are captured on that edge.
  - While busy, req_valid is ignored and must be held by the requester.
- Cycle numbering: accept cycle = cycle 0.
- States: IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_STROBE, RD_TURN. One down-counter is reloaded on each state entry.
- Write sequence:
  - Cycles 1..SETUP_CYC: WR_SETUP, oe=1, data_o=wdata, W=0.
  - Next STROBE_CYC cycles: WR_STROBE, W=1.
  - Next HOLD_CYC cycles: WR_HOLD, W=0, data still driven.
  - Cycle SETUP+STROBE+HOLD+1: IDLE, oe=0, done=1, req_ready=1.
  - Defaults: W high in cycles 3..6, done in cycle 9.
- Read sequence:
  - Cycles 1..STROBE_CYC: RD_STROBE, R=1, oe=0.
  - link_data_i passes through a 2-flop synchronizer. rsp_rdata loads the synchronizer output on the edge ending the last RD_STROBE cycle, so pad data must be stable from cycle STROBE_CYC-2.
  - Next TURN_CYC cycles: RD_TURN, R=0.
  - Cycle STROBE+TURN+1: IDLE, done=1, rsp_rdata valid.
  - Defaults: done in cycle 7.
- Back-to-back: a new request can be accepted in the same cycle that done=1. The next sequence starts in the following cycle.
- Reset mid-operation: on the rst edge all outputs return to their reset values. W or R fall on that edge, the bus is released, no done is issued, and the captured request is discarded.
- Illegal parameter values (below the minimums, or not fitting CNT_W) cause an elaboration-time error.

Decomposition:
- Shared package fpga_link_pkg:
  - state enum (link_state_t)
  - default timing constants (LINK_SETUP_CYC, LINK_STROBE_CYC, LINK_HOLD_CYC, LINK_TURN_CYC)
  - LINK_DATA_W=8
- One sub-module, fpga_link_sync: parameterised-width 2-flop synchronizer for link_data_i, reset to 0.
- FSM and counter stay in the top module.

Test Plan:
- Write 0xA5, default parameters -> data_o=0xA5 with oe=1 in cycles 1..8; W=1 exactly in cycles 3..6; R=0 throughout; done=1 in cycle 9 only; oe=0 in cycle 9.
- Read with the bench driving link_data_i=0x3C while R=1 -> R=1 in cycles 1..4, oe=0 throughout, done=1 with rsp_rdata=0x3C in cycle 7, req_ready=0 in cycles 1..6.
- Back-to-back write 0x11 then read (bench returns 0xF0), req_valid held high -> second accept in cycle 9, R rises in cycle 10, second done in cycle 16 with rsp_rdata=0xF0; W and R never overlap.
- rst asserted in cycle 4 of a write -> W=0, oe=0, req_ready=1 from cycle 5; no done pulse; a following read completes normally.
- STROBE_CYC=3, TURN_CYC=1, read with link_data_i changing to 0x7E at cycle 1 -> rsp_rdata=0x7E, done in cycle 5.
- Throughout all tests, an assertion checks that W and R are never high together, that W is only high with oe=1, and that R is only high with oe=0.
